regfile_wb_scheduler: RTL



---
 rtl/regfile_wb_scheduler_pkg.sv | 29 ++
 rtl/regfile_wb_scheduler_arb.sv | 43 ++++
 rtl/regfile_wb_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_scheduler_pkg
//  Purpose  : Shared types and constants for the register-file write-back
//             scheduler: controller states, write-source codes and the
//             register address width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_scheduler_pkg;

    localparam int REG_ADDR_W = 5;

    // Controller states: normal arbitration, or sweeping zeros into the file.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Source of an accepted transfer, as reported on last_grant.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2,
        SRC_DBG  = 2'd3
    } src_t;

endpackage : regfile_wb_scheduler_pkg
`default_nettype wire

// File: rtl/regfile_wb_scheduler_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rf_rr_arb2
//  Purpose  : Two-requester round-robin arbiter with one-hot grant. The
//             pointer selects which requester wins when both request, and
//             toggles whenever the advance input is high on a rising edge.
//  Ports    : clk      - clock
//             reset    - asynchronous active-low reset (pointer favours req[0])
//             req[1:0] - request vector (bit 0 = ALU, bit 1 = load)
//             advance  - toggle the pointer at the next rising edge
//             gnt[1:0] - one-hot grant, combinational from req and pointer
//  Revision : 1.0 - initial release
// ============================================================================
module rf_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0: req[0] wins a tie, 1: req[1] wins a tie.
    logic r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    // A lone request (or none) passes straight through; only a tie consults
    // the pointer.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule : rf_rr_arb2
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_scheduler
//  Purpose  : Schedules writes into a register file from three requesters
//             (debug, ALU, load) with valid/ready handshakes, and performs a
//             multi-cycle clear sweep of registers 1..NREGS-1 on command.
//             All register-file drive signals come straight from flops.
//  Ports    : clk, reset (async active-low)
//             alu_valid/alu_ready/alu_rd/alu_data  - ALU write-back
//             ld_valid/ld_ready/ld_rd/ld_data      - load write-back
//             dbg_valid/dbg_ready/dbg_rd/dbg_data  - debug write
//             clr_start/clr_busy/clr_done          - clear command/status
//             rf_we/rf_rd/rf_data                  - register file write port
//             last_grant                           - source of last transfer
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [WIDTH-1:0]      ld_data,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic [REG_ADDR_W-1:0] dbg_rd,
    input  logic [WIDTH-1:0]      dbg_data,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [WIDTH-1:0]      rf_data,
    output logic [1:0]            last_grant
);

    localparam logic [REG_ADDR_W-1:0] C_FIRST_REG = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] C_LAST_REG  = REG_ADDR_W'(NREGS - 1);

    // Registered state
    state_t                  r_state;
    logic [REG_ADDR_W-1:0]   r_cnt;
    logic                    r_we;
    logic [REG_ADDR_W-1:0]   r_rd;
    logic [WIDTH-1:0]        r_data;
    logic                    r_done;
    src_t                    r_lg;

    // Next-state values
    state_t                  w_state_nxt;
    logic [REG_ADDR_W-1:0]   w_cnt_nxt;
    logic                    w_we_nxt;
    logic [REG_ADDR_W-1:0]   w_rd_nxt;
    logic [WIDTH-1:0]        w_data_nxt;
    logic                    w_done_nxt;
    src_t                    w_lg_nxt;

    // Handshake / selection
    logic                    w_accept_ok;
    logic [1:0]              w_arb_req;
    logic [1:0]              w_arb_gnt;
    logic                    w_arb_adv;
    logic                    w_xfer;
    logic [REG_ADDR_W-1:0]   w_sel_rd;
    logic [WIDTH-1:0]        w_sel_data;
    src_t                    w_sel_src;

    // Requests are only taken in IDLE, out of reset, and never in the cycle a
    // clear is launched, so the clear command always beats pending writes.
    assign w_accept_ok = reset && (r_state == ST_IDLE) && !clr_start;

    assign dbg_ready = w_accept_ok && dbg_valid;
    // Debug has absolute priority: mask ALU/load off the arbiter while it asks.
    assign w_arb_req = {ld_valid, alu_valid} & {2{w_accept_ok && !dbg_valid}};

    rf_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_arb_req),
        .advance (w_arb_adv),
        .gnt     (w_arb_gnt)
    );

    assign alu_ready = w_arb_gnt[0];
    assign ld_ready  = w_arb_gnt[1];

    // The pointer moves only when ALU and load actually contended and one won.
    assign w_arb_adv = alu_valid && ld_valid && (alu_ready || ld_ready);

    assign w_xfer = dbg_ready || alu_ready || ld_ready;

    always_comb begin
        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
        w_sel_src  = SRC_ALU;
        if (dbg_ready) begin
            w_sel_rd   = dbg_rd;
            w_sel_data = dbg_data;
            w_sel_src  = SRC_DBG;
        end else if (ld_ready) begin
            w_sel_rd   = ld_rd;
            w_sel_data = ld_data;
            w_sel_src  = SRC_LD;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = 1'b0;
        w_rd_nxt    = r_rd;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_lg_nxt    = r_lg;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    // First sweep write appears together with clr_busy.
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = C_FIRST_REG;
                    w_we_nxt    = 1'b1;
                    w_rd_nxt    = C_FIRST_REG;
                    w_data_nxt  = '0;
                end else if (w_xfer) begin
                    // x0 is hard-wired: accept the transfer but do not write.
                    w_we_nxt   = (w_sel_rd != '0);
                    w_rd_nxt   = w_sel_rd;
                    w_data_nxt = w_sel_data;
                    w_lg_nxt   = w_sel_src;
                end
            end
            ST_CLEAR: begin
                // r_cnt is the register being written during this cycle.
                if (r_cnt == C_LAST_REG) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + C_FIRST_REG;
                    w_we_nxt   = 1'b1;
                    w_rd_nxt   = r_cnt + C_FIRST_REG;
                    w_data_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_lg    <= SRC_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_we_nxt;
            r_rd    <= w_rd_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_lg    <= w_lg_nxt;
        end
    end

    assign rf_we      = r_we;
    assign rf_rd      = r_rd;
    assign rf_data    = r_data;
    assign clr_busy   = (r_state == ST_CLEAR);
    assign clr_done   = r_done;
    assign last_grant = r_lg;

endmodule : regfile_wb_scheduler
`default_nettype wire
